// File: rtl/instr_control_unit.sv
// Moore controller that sequences the PC, IR, data memory, register file and ALU
// through fetch/decode/execute for one 16-bit instruction per pass.
module instr_control_unit #(
    parameter logic [2:0] ALU_PASS = 3'd0,
    parameter logic [2:0] ALU_ADD  = 3'd1,
    parameter logic [2:0] ALU_SUB  = 3'd2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  OutState
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_opcode;

    assign w_opcode = IR[15:12];

    // State register; reset takes effect immediately, not at the next edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused opcodes decode as NOOP
    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_NOOP:  w_next = S_NOOP;
                    OP_STORE: w_next = S_STORE;
                    OP_LOAD:  w_next = S_LOAD_A;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_NOOP;
                endcase
            end
            S_NOOP:   w_next = S_FETCH;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Moore outputs decoded from state and the held instruction fields
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = ALU_PASS;
        case (r_state)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            // Load_A only covers the synchronous memory read latency
            S_LOAD_A: begin
                D_addr = IR[11:4];
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                RF_s       = 1'b0;
                ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign OutState = 4'(r_state);

endmodule

// File: tb/tb_instr_control_unit.sv
// Randomized bench for instr_control_unit: a per-instruction state-sequence model
// plus a table of per-state outputs is compared against the DUT every cycle.
module tb_instr_control_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_state;
    bit         chk_en = 1'b0;

    instr_control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a state, read straight from the state/output table
    always @(negedge Clk) begin
        if (chk_en) begin
            logic       e_clr, e_up, e_ld, e_wr, e_s, e_wen;
            logic [7:0] e_daddr;
            logic [3:0] e_wa, e_ra, e_rb;
            logic [2:0] e_alu;
            {e_clr, e_up, e_ld, e_wr, e_s, e_wen} = 6'b0;
            e_daddr = 8'd0; e_wa = 4'd0; e_ra = 4'd0; e_rb = 4'd0; e_alu = 3'd0;
            case (exp_state)
                4'd0: e_clr = 1'b1;
                4'd1: begin e_ld = 1'b1; e_up = 1'b1; end
                4'd4: begin e_daddr = IR[11:4]; e_s = 1'b1; end
                4'd5: begin e_daddr = IR[11:4]; e_s = 1'b1; e_wa = IR[3:0]; e_wen = 1'b1; end
                4'd6: begin e_daddr = IR[7:0]; e_ra = IR[11:8]; e_wr = 1'b1; end
                4'd7, 4'd8: begin
                    e_ra = IR[11:8]; e_rb = IR[7:4]; e_wa = IR[3:0]; e_wen = 1'b1;
                    e_alu = (exp_state == 4'd7) ? 3'd1 : 3'd2;
                end
                default: ;
            endcase
            chk("OutState",   16'(OutState),   16'(exp_state));
            chk("PC_clr",     16'(PC_clr),     16'(e_clr));
            chk("PC_up",      16'(PC_up),      16'(e_up));
            chk("IR_ld",      16'(IR_ld),      16'(e_ld));
            chk("D_addr",     16'(D_addr),     16'(e_daddr));
            chk("D_wr",       16'(D_wr),       16'(e_wr));
            chk("RF_s",       16'(RF_s),       16'(e_s));
            chk("RF_W_addr",  16'(RF_W_addr),  16'(e_wa));
            chk("RF_W_en",    16'(RF_W_en),    16'(e_wen));
            chk("RF_Ra_addr", 16'(RF_Ra_addr), 16'(e_ra));
            chk("RF_Rb_addr", 16'(RF_Rb_addr), 16'(e_rb));
            chk("ALU_s0",     16'(ALU_s0),     16'(e_alu));
            chk("excl_wr",    16'(D_wr & RF_W_en), 16'd0);
            chk("excl_pc",    16'(PC_clr & PC_up), 16'd0);
        end
    end

    // Advance one clock and declare which state the DUT must now be in
    task automatic step(input logic [3:0] st);
        @(posedge Clk);
        #1;
        exp_state = st;
    endtask

    // Asynchronous reset pulse between edges, checked before any edge arrives
    task automatic reset_pulse();
        #1;
        Reset = 1'b1;
        exp_state = 4'd0;
        #1;
        chk("async_state", 16'(OutState), 16'd0);
        chk("async_clr",   16'(PC_clr),   16'd1);
        chk("async_wen",   16'(RF_W_en),  16'd0);
        Reset = 1'b0;
    endtask

    // One instruction from Fetch onward; state sequence follows from the opcode
    task automatic run_instr(input logic [15:0] instr, input bit abort, input int halt_cycles);
        step(4'd1);
        IR = instr;
        step(4'd2);
        case (instr[15:12])
            4'h1: step(4'd6);
            4'h2: begin
                step(4'd4);
                if (abort) begin reset_pulse(); return; end
                step(4'd5);
            end
            4'h3: step(4'd7);
            4'h4: step(4'd8);
            4'h5: begin
                repeat (halt_cycles) step(4'd9);
                reset_pulse();
                return;
            end
            default: step(4'd3);
        endcase
        if (abort) reset_pulse();
    endtask

    initial begin
        Reset = 1'b1;
        IR = 16'h0000;
        exp_state = 4'd0;
        #1;
        chk_en = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_clr", 16'(PC_clr), 16'd1);
        Reset = 1'b0;

        // ADD interrupted by reset, then SUB
        step(4'd1); IR = 16'h3125;
        step(4'd2);
        step(4'd7);
        chk("add_ra", 16'(RF_Ra_addr), 16'd1);
        chk("add_rb", 16'(RF_Rb_addr), 16'd2);
        chk("add_wa", 16'(RF_W_addr),  16'd5);
        chk("add_alu", 16'(ALU_s0),    16'd1);
        chk("add_wen", 16'(RF_W_en),   16'd1);
        reset_pulse();
        step(4'd1);
        chk("post_rst_state", 16'(OutState), 16'd1);
        chk("post_rst_ld",    16'(IR_ld),    16'd1);
        chk("post_rst_up",    16'(PC_up),    16'd1);
        IR = 16'h4125;
        step(4'd2);
        step(4'd8);
        chk("sub_alu", 16'(ALU_s0), 16'd2);
        chk("sub_rs",  16'(RF_s),   16'd0);

        // LOAD 0x1B -> R3
        step(4'd1); IR = 16'h21B3;
        step(4'd2);
        step(4'd4);
        chk("lda_addr", 16'(D_addr),  16'h1B);
        chk("lda_rs",   16'(RF_s),    16'd1);
        chk("lda_wen",  16'(RF_W_en), 16'd0);
        step(4'd5);
        chk("ldb_wen",  16'(RF_W_en),   16'd1);
        chk("ldb_wa",   16'(RF_W_addr), 16'd3);

        // STORE RA -> 0x42
        step(4'd1); IR = 16'h1A42;
        step(4'd2);
        step(4'd6);
        chk("st_wr",   16'(D_wr),       16'd1);
        chk("st_addr", 16'(D_addr),     16'h42);
        chk("st_ra",   16'(RF_Ra_addr), 16'hA);
        chk("st_wen",  16'(RF_W_en),    16'd0);

        // Unused opcode behaves as NOOP
        step(4'd1); IR = 16'hF123;
        step(4'd2);
        step(4'd3);
        chk("nop_state", 16'(OutState), 16'd3);
        chk("nop_wr",    16'(D_wr),     16'd0);
        chk("nop_wen",   16'(RF_W_en),  16'd0);

        // HALT held for 20 clocks, released only by reset
        run_instr(16'h5000, 1'b0, 20);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] instr;
            bit          abort;
            instr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) instr[15:12] = 4'($urandom_range(0, 5));
            abort = ($urandom_range(0, 19) == 0);
            run_instr(instr, abort, int'($urandom_range(1, 20)));
        end

        step(4'd1);
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
